// File: rtl/medarb_pkg.sv
// Shared types and constants for the median-filter arbiter.
// The optional WAIT watchdog is enabled by defining MEDARB_TIMEOUT_EN.
package medarb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int BURST_LEN = 9;
    localparam int BEAT_W    = 4;

    // Width of an encoded client index; never narrower than one bit.
    function automatic int ptr_width(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/medarb_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping around. o_pick is all-zero when nothing is requested.
module medarb_rr_pick
    import medarb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]            i_req,
    input  logic [ptr_width(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]            o_pick,
    output logic [ptr_width(NREQ)-1:0] o_idx
);

    localparam int PW = ptr_width(NREQ);

    logic [NREQ-1:0] w_rot;
    logic [PW:0]     w_sum;
    logic            w_found;

    // Rotate so the pointer position lands at bit 0, then scan upward.
    assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_found = 1'b0;
        w_sum   = '0;
        o_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, i_ptr} + (PW+1)'(k);
                if (w_sum >= (PW+1)'(NREQ)) begin
                    w_sum = w_sum - (PW+1)'(NREQ);
                end
                o_idx = w_sum[PW-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pick
        assign o_pick[gi] = w_found && (o_idx == PW'(gi));
    end

endmodule

// File: rtl/median_arbiter.sv
// Round-robin arbiter sharing one 3x3 median unit between NREQ pixel streams.
// Define MEDARB_TIMEOUT_EN to add a watchdog that aborts a stalled WAIT.
module median_arbiter
    import medarb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 63
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       REQ,
    output logic [NREQ-1:0]       GNT,
    input  logic [NREQ*WIDTH-1:0] DI,
    input  logic [NREQ-1:0]       DSI,
    output logic [WIDTH-1:0]      DO,
    output logic [NREQ-1:0]       DSO,
    output logic                  ERR,
    output logic                  BUSY,
    output logic [WIDTH-1:0]      M_DI,
    output logic                  M_DSI,
    output logic                  M_nRST,
    input  logic [WIDTH-1:0]      M_DO,
    input  logic                  M_DSO
);

    localparam int PW = ptr_width(NREQ);

    if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1) begin : g_param_check
        $error("median_arbiter: NREQ must be 2..4 and TIMEOUT at least 1");
    end

    state_t            r_state, r_state_next;
    logic [PW-1:0]     r_owner, r_owner_next;
    logic [PW-1:0]     r_ptr, r_ptr_next;
    logic [BEAT_W-1:0] r_beat, r_beat_next;
    logic [NREQ-1:0]   r_gnt, r_gnt_next;
    logic [NREQ-1:0]   r_dso, r_dso_next;
    logic [WIDTH-1:0]  r_do, r_do_next;
    logic              r_err, r_err_next;
    logic              r_flush, r_flush_next;

`ifdef MEDARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]  r_tmo, r_tmo_next;
`endif

    logic [NREQ-1:0]   w_pick;
    logic [PW-1:0]     w_pick_idx;
    logic [NREQ-1:0]   w_owner_oh;
    logic [PW-1:0]     w_ptr_after;
    logic [WIDTH-1:0]  w_own_di;
    logic              w_own_dsi;
    logic              w_own_req;

    medarb_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req  (REQ),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner_oh
        assign w_owner_oh[gi] = (r_owner == PW'(gi));
    end

    always_comb begin
        w_own_di = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_own_di = w_own_di | (DI[k*WIDTH +: WIDTH] & {WIDTH{w_owner_oh[k]}});
        end
    end

    assign w_own_dsi   = |(DSI & w_owner_oh);
    assign w_own_req   = |(REQ & w_owner_oh);
    assign w_ptr_after = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);

    // The unit only sees the owner's stream, and only while it is loading.
    assign M_DI   = (r_state == LOAD) ? w_own_di : '0;
    assign M_DSI  = (r_state == LOAD) && w_own_dsi;
    assign M_nRST = nRST && !r_flush;

    assign GNT  = r_gnt;
    assign DSO  = r_dso;
    assign DO   = r_do;
    assign ERR  = r_err;
    assign BUSY = (r_state != IDLE);

    always_comb begin
        r_state_next = r_state;
        r_owner_next = r_owner;
        r_ptr_next   = r_ptr;
        r_beat_next  = r_beat;
        r_gnt_next   = r_gnt;
        r_dso_next   = '0;
        r_do_next    = r_do;
        r_err_next   = 1'b0;
        r_flush_next = 1'b0;
`ifdef MEDARB_TIMEOUT_EN
        r_tmo_next   = r_tmo;
`endif
        case (r_state)
            IDLE: begin
                if (|REQ) begin
                    r_owner_next = w_pick_idx;
                    r_gnt_next   = w_pick;
                    r_beat_next  = '0;
                    r_state_next = LOAD;
                end
            end
            LOAD: begin
                if (w_own_dsi) begin
                    r_beat_next = r_beat + BEAT_W'(1);
                    if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
                        r_gnt_next   = '0;
                        r_state_next = WAIT;
`ifdef MEDARB_TIMEOUT_EN
                        r_tmo_next   = '0;
`endif
                    end
                end else if (r_beat == '0) begin
                    // Withdrawing before any beat is harmless: the unit saw nothing.
                    if (!w_own_req) begin
                        r_gnt_next   = '0;
                        r_ptr_next   = w_ptr_after;
                        r_state_next = IDLE;
                    end
                end else begin
                    r_err_next   = 1'b1;
                    r_flush_next = 1'b1;
                    r_gnt_next   = '0;
                    r_state_next = FLUSH;
                end
            end
            WAIT: begin
                if (M_DSO) begin
                    r_do_next    = M_DO;
                    r_dso_next   = w_owner_oh;
                    r_ptr_next   = w_ptr_after;
                    r_state_next = IDLE;
                end
`ifdef MEDARB_TIMEOUT_EN
                else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    r_err_next   = 1'b1;
                    r_flush_next = 1'b1;
                    r_state_next = FLUSH;
                end else begin
                    r_tmo_next = r_tmo + TMO_W'(1);
                end
`endif
            end
            FLUSH: begin
                r_ptr_next   = w_ptr_after;
                r_state_next = IDLE;
            end
            default: r_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_beat  <= '0;
            r_gnt   <= '0;
            r_dso   <= '0;
            r_do    <= '0;
            r_err   <= 1'b0;
            r_flush <= 1'b0;
`ifdef MEDARB_TIMEOUT_EN
            r_tmo   <= '0;
`endif
        end else begin
            r_state <= r_state_next;
            r_owner <= r_owner_next;
            r_ptr   <= r_ptr_next;
            r_beat  <= r_beat_next;
            r_gnt   <= r_gnt_next;
            r_dso   <= r_dso_next;
            r_do    <= r_do_next;
            r_err   <= r_err_next;
            r_flush <= r_flush_next;
`ifdef MEDARB_TIMEOUT_EN
            r_tmo   <= r_tmo_next;
`endif
        end
    end

endmodule

// File: tb/tb_median_arbiter.sv
// Directed bench for median_arbiter; the median unit is stubbed by driving
// M_DO/M_DSO directly. Honours MEDARB_TIMEOUT_EN for the watchdog scenario.
module tb_median_arbiter;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 20;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic [NREQ-1:0]       REQ;
    logic [NREQ-1:0]       GNT;
    logic [NREQ*WIDTH-1:0] DI;
    logic [NREQ-1:0]       DSI;
    logic [WIDTH-1:0]      DO;
    logic [NREQ-1:0]       DSO;
    logic                  ERR;
    logic                  BUSY;
    logic [WIDTH-1:0]      M_DI;
    logic                  M_DSI;
    logic                  M_nRST;
    logic [WIDTH-1:0]      M_DO;
    logic                  M_DSO;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    median_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST), .REQ(REQ), .GNT(GNT), .DI(DI), .DSI(DSI),
        .DO(DO), .DSO(DSO), .ERR(ERR), .BUSY(BUSY), .M_DI(M_DI), .M_DSI(M_DSI),
        .M_nRST(M_nRST), .M_DO(M_DO), .M_DSO(M_DSO)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Grant plus nine contiguous beats base, base+10, ..., ending in WAIT.
    task automatic load_burst(input int own, input logic [NREQ-1:0] req, input logic [WIDTH-1:0] base);
        logic [NREQ-1:0]  exp_g;
        logic [WIDTH-1:0] s;
        exp_g = '0;
        exp_g[own] = 1'b1;
        REQ = req;
        tick();
        checks++;
        if (GNT !== exp_g || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL grant: GNT=%b BUSY=%b, required GNT=%b BUSY=1", GNT, BUSY, exp_g);
        end
        for (int b = 0; b < 9; b++) begin
            s = base + WIDTH'(10 * b);
            DI[own*WIDTH +: WIDTH] = s;
            DSI = exp_g;
            #1;
            checks++;
            if (M_DSI !== 1'b1 || M_DI !== s) begin
                errors++;
                $display("FAIL beat%0d: M_DSI=%b M_DI=%h, required 1 %h", b, M_DSI, M_DI, s);
            end
            tick();
        end
        DSI = '0;
        #1;
        checks++;
        if (GNT !== '0 || BUSY !== 1'b1 || M_DSI !== 1'b0 || M_DI !== '0) begin
            errors++;
            $display("FAIL wait_entry: GNT=%b BUSY=%b M_DSI=%b M_DI=%h, required 00 1 0 00",
                     GNT, BUSY, M_DSI, M_DI);
        end
    endtask

    // Hold WAIT for lat cycles, then return mdo from the stub.
    task automatic finish_burst(input int own, input logic [WIDTH-1:0] mdo, input int lat);
        logic [NREQ-1:0] exp_d;
        int bad;
        exp_d = '0;
        exp_d[own] = 1'b1;
        bad = 0;
        repeat (lat) begin
            tick();
            if (DSO !== '0 || BUSY !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wait_hold: %0d bad cycles, required 0", bad);
        end
        M_DSO = 1'b1;
        M_DO  = mdo;
        tick();
        M_DSO = 1'b0;
        M_DO  = '0;
        checks++;
        if (DSO !== exp_d || DO !== mdo || BUSY !== 1'b0 || GNT !== '0) begin
            errors++;
            $display("FAIL result: DSO=%b DO=%h BUSY=%b GNT=%b, required %b %h 0 00",
                     DSO, DO, BUSY, GNT, exp_d, mdo);
        end
        $display("burst owner=%0d median=%h dso=%b", own, DO, DSO);
    endtask

    task automatic test_reset();
        nRST = 1'b0; REQ = '0; DI = '0; DSI = '0; M_DO = '0; M_DSO = 1'b0;
        tick();
        tick();
        checks++;
        if (GNT !== '0 || DSO !== '0 || DO !== '0 || ERR !== 1'b0 || BUSY !== 1'b0 || M_nRST !== 1'b0) begin
            errors++;
            $display("FAIL reset: GNT=%b DSO=%b DO=%h ERR=%b BUSY=%b M_nRST=%b, required all 0",
                     GNT, DSO, DO, ERR, BUSY, M_nRST);
        end
        nRST = 1'b1;
        tick();
        checks++;
        if (M_nRST !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: M_nRST=%b BUSY=%b, required 1 0", M_nRST, BUSY);
        end
        $display("reset done");
    endtask

    task automatic test_single();
        load_burst(0, 2'b01, 8'd10);
        finish_burst(0, 8'd50, 45);
        REQ = '0;
        tick();
        checks++;
        if (DSO !== '0 || DO !== 8'd50 || BUSY !== 1'b0 || GNT !== '0) begin
            errors++;
            $display("FAIL single_after: DSO=%b DO=%h BUSY=%b GNT=%b, required 00 32 0 00", DSO, DO, BUSY, GNT);
        end
    endtask

    task automatic test_fairness();
        nRST = 1'b0; REQ = '0;
        tick();
        nRST = 1'b1;
        tick();
        for (int n = 0; n < 4; n++) begin
            load_burst(n % 2, 2'b11, WIDTH'(8'h40 + n));
            finish_burst(n % 2, WIDTH'(8'h31 + n), 3);
        end
    endtask

    task automatic test_abort();
        load_burst_partial();
        REQ = 2'b10;
        tick();
        checks++;
        if (GNT !== '0 || BUSY !== 1'b0 || ERR !== 1'b0 || M_nRST !== 1'b1) begin
            errors++;
            $display("FAIL req_drop: GNT=%b BUSY=%b ERR=%b M_nRST=%b, required 00 0 0 1", GNT, BUSY, ERR, M_nRST);
        end
        REQ = 2'b11;
        tick();
        checks++;
        if (GNT !== 2'b10) begin
            errors++;
            $display("FAIL grant_after_drop: GNT=%b, required 10", GNT);
        end
    endtask

    // Client 1 stops after four beats; the burst must be flushed.
    task automatic load_burst_partial();
        REQ = 2'b10;
        tick();
        checks++;
        if (GNT !== 2'b10) begin
            errors++;
            $display("FAIL abort_grant: GNT=%b, required 10", GNT);
        end
        for (int b = 0; b < 4; b++) begin
            DI[WIDTH +: WIDTH] = WIDTH'(8'h60 + b);
            DSI = 2'b10;
            tick();
        end
        DSI = '0;
        REQ = 2'b11;
        tick();
        checks++;
        if (ERR !== 1'b1 || M_nRST !== 1'b0 || GNT !== '0 || BUSY !== 1'b1 || DSO !== '0) begin
            errors++;
            $display("FAIL abort: ERR=%b M_nRST=%b GNT=%b BUSY=%b DSO=%b, required 1 0 00 1 00",
                     ERR, M_nRST, GNT, BUSY, DSO);
        end
        tick();
        checks++;
        if (ERR !== 1'b0 || M_nRST !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL flush_end: ERR=%b M_nRST=%b BUSY=%b, required 0 1 0", ERR, M_nRST, BUSY);
        end
        tick();
        checks++;
        if (GNT !== 2'b01) begin
            errors++;
            $display("FAIL grant_after_abort: GNT=%b, required 01", GNT);
        end
        $display("abort owner=1 flushed, regrant=%b", GNT);
    endtask

    task automatic test_non_owner();
        logic [WIDTH-1:0] s;
        DSI = 2'b01;
        DI  = {8'h11, 8'hAA};
        #1;
        checks++;
        if (M_DSI !== 1'b0 || M_DI !== 8'h11) begin
            errors++;
            $display("FAIL non_owner_idle: M_DSI=%b M_DI=%h, required 0 11", M_DSI, M_DI);
        end
        tick();
        for (int b = 0; b < 9; b++) begin
            s = WIDTH'(8'h21 + b);
            DI  = {s, WIDTH'(8'hA0 + b)};
            DSI = {1'b1, b[0]};
            #1;
            checks++;
            if (M_DSI !== 1'b1 || M_DI !== s) begin
                errors++;
                $display("FAIL non_owner_beat%0d: M_DSI=%b M_DI=%h, required 1 %h", b, M_DSI, M_DI, s);
            end
            tick();
        end
        DSI = '0;
        checks++;
        if (BUSY !== 1'b1 || GNT !== '0) begin
            errors++;
            $display("FAIL non_owner_wait: BUSY=%b GNT=%b, required 1 00", BUSY, GNT);
        end
        $display("non-owner burst owner=1 loaded");
    endtask

    task automatic test_reset_in_wait();
        REQ  = '0;
        nRST = 1'b0;
        tick();
        checks++;
        if (GNT !== '0 || DSO !== '0 || DO !== '0 || ERR !== 1'b0 || BUSY !== 1'b0 || M_nRST !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait: GNT=%b DSO=%b DO=%h ERR=%b BUSY=%b M_nRST=%b, required all 0",
                     GNT, DSO, DO, ERR, BUSY, M_nRST);
        end
        nRST  = 1'b1;
        M_DSO = 1'b1;
        M_DO  = 8'h77;
        tick();
        M_DSO = 1'b0;
        M_DO  = '0;
        tick();
        checks++;
        if (DSO !== '0 || DO !== '0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL late_mdso: DSO=%b DO=%h BUSY=%b, required 00 00 0", DSO, DO, BUSY);
        end
        $display("reset in WAIT, late result ignored");
    endtask

    task automatic test_timeout();
        int bad;
        load_burst(0, 2'b01, 8'd5);
        REQ = '0;
        bad = 0;
`ifdef MEDARB_TIMEOUT_EN
        repeat (TIMEOUT - 1) begin
            tick();
            if (ERR !== 1'b0 || BUSY !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_early: %0d bad cycles, required 0", bad);
        end
        tick();
        checks++;
        if (ERR !== 1'b1 || M_nRST !== 1'b0 || DSO !== '0) begin
            errors++;
            $display("FAIL timeout: ERR=%b M_nRST=%b DSO=%b, required 1 0 00", ERR, M_nRST, DSO);
        end
        tick();
        checks++;
        if (ERR !== 1'b0 || BUSY !== 1'b0 || M_nRST !== 1'b1) begin
            errors++;
            $display("FAIL timeout_end: ERR=%b BUSY=%b M_nRST=%b, required 0 0 1", ERR, BUSY, M_nRST);
        end
        $display("timeout abort owner=0");
`else
        repeat (2 * TIMEOUT) begin
            tick();
            if (ERR !== 1'b0 || BUSY !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_timeout: %0d bad cycles, required 0", bad);
        end
        finish_burst(0, 8'h99, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_abort();
        test_non_owner();
        test_reset_in_wait();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule
